l1d_bus_ctrl: RTL
=================

# l1d_bus_ctrl

Bus-side responder for the L1 data cache miss/writeback request interface. Accepts single read, write-through, line refill and line writeback requests from the L1D and runs them as 64-bit single-beat transfers on the core's memory bus. It drives the beat counter, refill data and write strobes back into the cache SRAM, and returns completion or error. It sits between the L1D and the BIU bus arbiter.

## Interface
- LINE_BEATS, 1024: 64-bit beats per cache line; power of two, 2..1024.
- TIMEOUT_CYCLES, 256: bus watchdog limit; used only with the watchdog macro.

- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- write_through_req  in  1  single write request
- read_req  in  1  single (uncacheable) read request
- read_line_req  in  1  line refill request
- write_line_req  in  1  dirty line writeback request
- L1_size  in  4  0001/0010/0100/1000 = 1/2/4/8 bytes
- pa  in  64  physical address
- wt_data  in  64  write data; during writeback, cache SRAM output for addr_count
- line_data  out  64  registered read data to cache
- addr_count  out  11  beat index for cache SRAM access
- line_write  out  1  cache write strobe for line_data at addr_count
- cache_entry_refill  out  1  line refill complete, update tag
- trans_rdy  out  1  transaction complete, 1-cycle pulse
- bus_error  out  1  transaction failed, 1-cycle pulse
- bus_req  out  1  bus request, held until ack or err
- bus_we  out  1  1 = write
- bus_addr  out  64  byte address
- bus_wdata  out  64  write data
- bus_bsel  out  8  byte lanes
- bus_rdata  in  64  read data, valid with bus_ack
- bus_ack  in  1  beat done
- bus_err  in  1  beat failed, takes priority over bus_ack

## Operation
- States: IDLE, RD_S, WR_S, RL_REQ, RL_WR, WB_FETCH, WB_CAPT, WB_REQ, DONE, ERR.
- IDLE priority: write_line_req > read_line_req > read_req > write_through_req. On acceptance, latch pa, L1_size and the line base (pa with the low log2(LINE_BEATS*8) bits cleared). Clear the beat counter.
- RD_S / WR_S: issue bus_req at the latched pa. bus_bsel is derived from size and pa[2:0]. For 8 bytes it is 0xFF; otherwise it is ((1<<size_bytes)-1)<<pa[2:0]. bus_wdata is wt_data, registered at acceptance.
- RL_REQ: bus_addr = base + count*8, bus_bsel = 0xFF. On ack, line_data <= bus_rdata and go to RL_WR.
- RL_WR: line_write = 1 with addr_count = count. If count is the last beat, go to DONE with refill. Otherwise increment count and return to RL_REQ.
- WB_FETCH: addr_count = count; the cache SRAM reads on this edge. WB_CAPT: register wt_data into bus_wdata. WB_REQ: bus write at base + count*8. On ack, if count is the last beat, go to DONE; otherwise increment count and go to WB_FETCH.
- DONE lasts one cycle and outputs trans_rdy = 1. It also outputs cache_entry_refill = 1 if the op was a refill. All requests are ignored in DONE, because the cache still holds its request during this cycle. DONE then returns to IDLE.
- bus_err in any bus state goes to ERR. ERR lasts one cycle, outputs bus_error = 1 and no trans_rdy, then returns to IDLE. A partially filled line is never marked refilled.
- addr_count wraps at LINE_BEATS; its upper bits are zero.

## Timing
- Reset: all outputs 0, state IDLE, counter 0. Reset mid-transfer drops bus_req on the next edge with no trans_rdy or bus_error.
- Request sampled at edge t. bus_req is high from t+1.
- Ack at edge k: DONE (trans_rdy) in cycle k+1, IDLE at k+2. Minimum single read is 3 cycles for a zero-wait bus.
- Refill costs 2 cycles/beat plus DONE. Writeback costs 3 cycles/beat plus DONE.
- Between beats, bus_req is low for at least 1 cycle. bus_addr, bus_we, bus_wdata and bus_bsel are stable while bus_req is high.
- Back-to-back requests are allowed: a writeback followed by a refill has read_line_req sampled in IDLE at k+2.

## Configuration
- L1_BUS_TIMEOUT_EN defined: a counter runs while bus_req is high and neither ack nor err has arrived. At TIMEOUT_CYCLES it aborts the transfer: bus_req drops and the block goes to ERR (bus_error pulse).
- Undefined: no counter; the block waits indefinitely for ack/err.

## Test plan
- read_req, pa=0x1003, size=0001, ack after 2 cycles with rdata=0xAB -> bus_bsel=0x08, line_data=0xAB with one trans_rdy pulse, back to IDLE.
- write_through_req, pa=0x2004, size=0100, wt_data=0x11223344 -> bus_we=1, bsel=0xF0, addr=0x2004, single trans_rdy.
- LINE_BEATS=4, read_line_req pa=0x1038, rdata=beat index -> addr 0x1020..0x1038, line_write×4 with addr_count 0..3, trans_rdy and cache_entry_refill together once.
- LINE_BEATS=4, write_line_req with wt_data=f(addr_count) -> 4 bus writes, each bus_wdata matches the SRAM value for its beat; after DONE a held write_line_req starts a new writeback.
- Refill with bus_err on beat 2 -> bus_error pulse, no refill or trans_rdy, line_write only for beats 0-1.
- L1_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, no ack -> bus_error 8 cycles after bus_req rises; without the macro, still waiting after 100 cycles.

Source files
------------

// File: rtl/l1d_bus_ctrl.sv
// L1D miss/writeback bus responder: single reads/writes, line refill and line writeback as 64-bit beats.
// Optional bus watchdog enabled by defining L1_BUS_TIMEOUT_EN.
module l1d_bus_ctrl #(
  parameter int LINE_BEATS     = 1024,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        write_through_req,
  input  logic        read_req,
  input  logic        read_line_req,
  input  logic        write_line_req,
  input  logic [3:0]  L1_size,
  input  logic [63:0] pa,
  input  logic [63:0] wt_data,
  output logic [63:0] line_data,
  output logic [10:0] addr_count,
  output logic        line_write,
  output logic        cache_entry_refill,
  output logic        trans_rdy,
  output logic        bus_error,
  output logic        bus_req,
  output logic        bus_we,
  output logic [63:0] bus_addr,
  output logic [63:0] bus_wdata,
  output logic [7:0]  bus_bsel,
  input  logic [63:0] bus_rdata,
  input  logic        bus_ack,
  input  logic        bus_err
);

  localparam int CW   = $clog2(LINE_BEATS);
  localparam int OFFW = CW + 3;
  localparam logic [63:0] OFF_MASK = (64'd1 << OFFW) - 64'd1;

  typedef enum logic [3:0] {
    IDLE, RD_S, WR_S, RL_REQ, RL_WR, WB_FETCH, WB_CAPT, WB_REQ, DONE, ERR
  } state_t;

  state_t      state, state_nxt;
  logic [CW-1:0] count;
  logic [63:0] pa_q, base_q;
  logic [3:0]  size_q;
  logic        refill_q;

  logic accept, count_inc, load_rdata, capt_wdata, wd_expire, last_beat;
  logic [7:0] size_mask, single_bsel;

  assign last_beat  = (count == CW'(LINE_BEATS - 1));
  assign addr_count = 11'(count);

`ifdef L1_BUS_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDW-1:0] wd_count;

  // Counts cycles of an outstanding beat; cleared whenever the bus is idle or answers.
  always_ff @(posedge clk) begin
    if (rst || !bus_req || bus_ack || bus_err)
      wd_count <= '0;
    else
      wd_count <= wd_count + 1'b1;
  end

  assign wd_expire = bus_req && !bus_ack && !bus_err &&
                     (wd_count == WDW'(TIMEOUT_CYCLES - 1));
`else
  assign wd_expire = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    case (size_q)
      4'b0001: size_mask = 8'h01;
      4'b0010: size_mask = 8'h03;
      4'b0100: size_mask = 8'h0F;
      4'b1000: size_mask = 8'hFF;
      default: size_mask = 8'h00;
    endcase
    single_bsel = (size_q == 4'b1000) ? 8'hFF : (size_mask << pa_q[2:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      pa_q      <= '0;
      base_q    <= '0;
      size_q    <= '0;
      refill_q  <= 1'b0;
      line_data <= '0;
      bus_wdata <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        pa_q      <= pa;
        size_q    <= L1_size;
        base_q    <= pa & ~OFF_MASK;
        refill_q  <= !write_line_req && read_line_req;
        bus_wdata <= wt_data;
        count     <= '0;
      end else if (count_inc) begin
        count <= count + 1'b1;
      end
      if (load_rdata)
        line_data <= bus_rdata;
      if (capt_wdata)
        bus_wdata <= wt_data;
    end
  end

  // bus_err outranks bus_ack, and the watchdog abort behaves like bus_err.
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    count_inc  = 1'b0;
    load_rdata = 1'b0;
    capt_wdata = 1'b0;
    case (state)
      IDLE: begin
        accept = write_line_req || read_line_req || read_req || write_through_req;
        if (write_line_req)         state_nxt = WB_FETCH;
        else if (read_line_req)     state_nxt = RL_REQ;
        else if (read_req)          state_nxt = RD_S;
        else if (write_through_req) state_nxt = WR_S;
      end
      RD_S: begin
        if (bus_err || wd_expire) state_nxt = ERR;
        else if (bus_ack) begin
          load_rdata = 1'b1;
          state_nxt  = DONE;
        end
      end
      WR_S: begin
        if (bus_err || wd_expire) state_nxt = ERR;
        else if (bus_ack)         state_nxt = DONE;
      end
      RL_REQ: begin
        if (bus_err || wd_expire) state_nxt = ERR;
        else if (bus_ack) begin
          load_rdata = 1'b1;
          state_nxt  = RL_WR;
        end
      end
      RL_WR: begin
        if (last_beat) state_nxt = DONE;
        else begin
          count_inc = 1'b1;
          state_nxt = RL_REQ;
        end
      end
      WB_FETCH: state_nxt = WB_CAPT;
      WB_CAPT: begin
        capt_wdata = 1'b1;
        state_nxt  = WB_REQ;
      end
      WB_REQ: begin
        if (bus_err || wd_expire) state_nxt = ERR;
        else if (bus_ack) begin
          if (last_beat) state_nxt = DONE;
          else begin
            count_inc = 1'b1;
            state_nxt = WB_FETCH;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus_req            = 1'b0;
    bus_we             = 1'b0;
    bus_addr           = '0;
    bus_bsel           = '0;
    line_write         = (state == RL_WR);
    trans_rdy          = (state == DONE);
    cache_entry_refill = (state == DONE) && refill_q;
    bus_error          = (state == ERR);
    case (state)
      RD_S: begin
        bus_req  = 1'b1;
        bus_addr = pa_q;
        bus_bsel = single_bsel;
      end
      WR_S: begin
        bus_req  = 1'b1;
        bus_we   = 1'b1;
        bus_addr = pa_q;
        bus_bsel = single_bsel;
      end
      RL_REQ: begin
        bus_req  = 1'b1;
        bus_addr = base_q + (64'(count) << 3);
        bus_bsel = 8'hFF;
      end
      WB_REQ: begin
        bus_req  = 1'b1;
        bus_we   = 1'b1;
        bus_addr = base_q + (64'(count) << 3);
        bus_bsel = 8'hFF;
      end
      default: ;
    endcase
  end

endmodule
